// File: rtl/spu_ff_wb.sv
// SPU writeback/retire stage: per-pipe latency queues feeding the two
// register-file write ports, operand hazard lookup and branch redirect.
module spu_ff_wb #(
  parameter int DEPTH  = 7,
  parameter int LAT_U0 = 2,
  parameter int LAT_U1 = 4,
  parameter int LAT_U2 = 6,
  parameter int LAT_U3 = 6,
  parameter int LAT_U4 = 4,
  parameter int LAT_U5 = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] ff_rt_e,
  input  logic [6:0]   ff_rtaddr_e,
  input  logic         ff_wreg_e,
  input  logic [2:0]   ff_uid_e,
  input  logic [127:0] ff_rt_o,
  input  logic [6:0]   ff_rtaddr_o,
  input  logic         ff_wreg_o,
  input  logic [2:0]   ff_uid_o,
  input  logic         ff_branch_flag,
  input  logic [31:0]  ff_branch_target_addr,
  input  logic [6:0]   rd_addr_a,
  input  logic [6:0]   rd_addr_b,
  input  logic [6:0]   rd_addr_c,
  output logic         wb_we_e,
  output logic [6:0]   wb_waddr_e,
  output logic [127:0] wb_wdata_e,
  output logic         wb_we_o,
  output logic [6:0]   wb_waddr_o,
  output logic [127:0] wb_wdata_o,
  output logic         hazard_a,
  output logic         hazard_b,
  output logic         hazard_c,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc,
  output logic         err_pulse,
  output logic [1:0]   err_status
);

  logic [DEPTH-1:0] ev_q, ev_d, ov_q, ov_d;
  logic [6:0]       ea_q [DEPTH];
  logic [6:0]       ea_d [DEPTH];
  logic [6:0]       oa_q [DEPTH];
  logic [6:0]       oa_d [DEPTH];
  logic [127:0]     ed_q [DEPTH];
  logic [127:0]     ed_d [DEPTH];
  logic [127:0]     od_q [DEPTH];
  logic [127:0]     od_d [DEPTH];

  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic [1:0]       err_status_q, err_status_d;

  int               lat_e, lat_o;
  logic             req_e, req_o, bad_e, bad_o;
  logic             coll_e, coll_o, ins_e, ins_o;
  logic             wr_clash;

  function automatic int lat_of(input logic [2:0] uid);
    case (uid)
      3'd0:    lat_of = LAT_U0;
      3'd1:    lat_of = LAT_U1;
      3'd2:    lat_of = LAT_U2;
      3'd3:    lat_of = LAT_U3;
      3'd4:    lat_of = LAT_U4;
      3'd5:    lat_of = LAT_U5;
      default: lat_of = 1;
    endcase
  endfunction

  // Insertion qualification, collision and bad-uid detection.
  always_comb begin
    lat_e  = lat_of(ff_uid_e);
    lat_o  = lat_of(ff_uid_o);
    req_e  = ff_wreg_e && (ff_uid_e <= 3'd5);
    req_o  = ff_wreg_o && (ff_uid_o <= 3'd5);
    bad_e  = ff_wreg_e && (ff_uid_e > 3'd5);
    bad_o  = ff_wreg_o && (ff_uid_o > 3'd5);
    coll_e = 1'b0;
    coll_o = 1'b0;
    // The entry that will shift into slot[L-1] currently sits in slot[L].
    for (int i = 1; i < DEPTH; i++) begin
      coll_e = coll_e | (ev_q[i] & (lat_e == i));
      coll_o = coll_o | (ov_q[i] & (lat_o == i));
    end
    coll_e       = coll_e & req_e;
    coll_o       = coll_o & req_o;
    ins_e        = req_e & ~coll_e;
    ins_o        = req_o & ~coll_o;
    err_pulse    = coll_e | coll_o | bad_e | bad_o;
    err_status_d = err_status_q | {bad_e | bad_o, coll_e | coll_o};
  end

  // Slot shift with insertion at the latency-selected slot.
  always_comb begin
    ev_d = {1'b0, ev_q[DEPTH-1:1]};
    ov_d = {1'b0, ov_q[DEPTH-1:1]};
    for (int i = 0; i < DEPTH - 1; i++) begin
      ea_d[i] = ea_q[i+1];
      ed_d[i] = ed_q[i+1];
      oa_d[i] = oa_q[i+1];
      od_d[i] = od_q[i+1];
    end
    ea_d[DEPTH-1] = 7'd0;
    ed_d[DEPTH-1] = 128'd0;
    oa_d[DEPTH-1] = 7'd0;
    od_d[DEPTH-1] = 128'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ins_e && (lat_e == i + 1)) begin
        ev_d[i] = 1'b1;
        ea_d[i] = ff_rtaddr_e;
        ed_d[i] = ff_rt_e;
      end else begin
        ev_d[i] = ev_d[i];
      end
      if (ins_o && (lat_o == i + 1)) begin
        ov_d[i] = 1'b1;
        oa_d[i] = ff_rtaddr_o;
        od_d[i] = ff_rt_o;
      end else begin
        ov_d[i] = ov_d[i];
      end
    end
  end

  // Operand hazard lookup over live inputs and every valid slot.
  always_comb begin
    hazard_a = (req_e && (ff_rtaddr_e == rd_addr_a)) || (req_o && (ff_rtaddr_o == rd_addr_a));
    hazard_b = (req_e && (ff_rtaddr_e == rd_addr_b)) || (req_o && (ff_rtaddr_o == rd_addr_b));
    hazard_c = (req_e && (ff_rtaddr_e == rd_addr_c)) || (req_o && (ff_rtaddr_o == rd_addr_c));
    for (int i = 0; i < DEPTH; i++) begin
      hazard_a = hazard_a | (ev_q[i] & (ea_q[i] == rd_addr_a)) | (ov_q[i] & (oa_q[i] == rd_addr_a));
      hazard_b = hazard_b | (ev_q[i] & (ea_q[i] == rd_addr_b)) | (ov_q[i] & (oa_q[i] == rd_addr_b));
      hazard_c = hazard_c | (ev_q[i] & (ea_q[i] == rd_addr_c)) | (ov_q[i] & (oa_q[i] == rd_addr_c));
    end
  end

  // State registers: retire queues, redirect and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_q             <= '0;
      ov_q             <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ea_q[i] <= 7'd0;
        oa_q[i] <= 7'd0;
        ed_q[i] <= 128'd0;
        od_q[i] <= 128'd0;
      end
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      err_status_q     <= 2'b00;
    end else begin
      ev_q             <= ev_d;
      ov_q             <= ov_d;
      for (int i = 0; i < DEPTH; i++) begin
        ea_q[i] <= ea_d[i];
        oa_q[i] <= oa_d[i];
        ed_q[i] <= ed_d[i];
        od_q[i] <= od_d[i];
      end
      redirect_valid_q <= ff_branch_flag;
      redirect_pc_q    <= ff_branch_flag ? ff_branch_target_addr : 32'd0;
      err_status_q     <= err_status_d;
    end
  end

  // Odd pipe wins a same-address retire; the even write is suppressed.
  assign wr_clash       = ev_q[0] & ov_q[0] & (ea_q[0] == oa_q[0]);
  assign wb_we_e        = ev_q[0] & ~wr_clash;
  assign wb_waddr_e     = wb_we_e ? ea_q[0] : 7'd0;
  assign wb_wdata_e     = wb_we_e ? ed_q[0] : 128'd0;
  assign wb_we_o        = ov_q[0];
  assign wb_waddr_o     = wb_we_o ? oa_q[0] : 7'd0;
  assign wb_wdata_o     = wb_we_o ? od_q[0] : 128'd0;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign err_status     = err_status_q;

endmodule

// File: tb/tb_spu_ff_wb.sv
// Directed self-checking bench for spu_ff_wb.
module tb_spu_ff_wb;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] ff_rt_e, ff_rt_o;
  logic [6:0]   ff_rtaddr_e, ff_rtaddr_o;
  logic         ff_wreg_e, ff_wreg_o;
  logic [2:0]   ff_uid_e, ff_uid_o;
  logic         ff_branch_flag;
  logic [31:0]  ff_branch_target_addr;
  logic [6:0]   rd_addr_a, rd_addr_b, rd_addr_c;
  logic         wb_we_e, wb_we_o;
  logic [6:0]   wb_waddr_e, wb_waddr_o;
  logic [127:0] wb_wdata_e, wb_wdata_o;
  logic         hazard_a, hazard_b, hazard_c;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         err_pulse;
  logic [1:0]   err_status;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  spu_ff_wb dut (
    .clk(clk), .rst(rst),
    .ff_rt_e(ff_rt_e), .ff_rtaddr_e(ff_rtaddr_e), .ff_wreg_e(ff_wreg_e), .ff_uid_e(ff_uid_e),
    .ff_rt_o(ff_rt_o), .ff_rtaddr_o(ff_rtaddr_o), .ff_wreg_o(ff_wreg_o), .ff_uid_o(ff_uid_o),
    .ff_branch_flag(ff_branch_flag), .ff_branch_target_addr(ff_branch_target_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .wb_we_e(wb_we_e), .wb_waddr_e(wb_waddr_e), .wb_wdata_e(wb_wdata_e),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .hazard_c(hazard_c),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .err_pulse(err_pulse), .err_status(err_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ff_rt_e = 128'd0; ff_rtaddr_e = 7'd0; ff_wreg_e = 1'b0; ff_uid_e = 3'd0;
    ff_rt_o = 128'd0; ff_rtaddr_o = 7'd0; ff_wreg_o = 1'b0; ff_uid_o = 3'd0;
    ff_branch_flag = 1'b0; ff_branch_target_addr = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    rd_addr_a = 7'd0; rd_addr_b = 7'd0; rd_addr_c = 7'd0;
    #1 rst = 1'b1;
    // In reset: outputs cleared, hazards follow live inputs only.
    ff_wreg_e = 1'b1; ff_uid_e = 3'd0; ff_rtaddr_e = 7'd5; rd_addr_a = 7'd5; rd_addr_b = 7'd6;
    #1;
    check("rst_we_e", 128'(wb_we_e), 128'd0);
    check("rst_we_o", 128'(wb_we_o), 128'd0);
    check("rst_redir", 128'(redirect_valid), 128'd0);
    check("rst_errst", 128'(err_status), 128'd0);
    check("rst_haz_live_a", 128'(hazard_a), 128'd1);
    check("rst_haz_b", 128'(hazard_b), 128'd0);
    idle();
    tick(); tick();
    rst = 1'b0;

    // Even uid0 (L=2) to r5: retires two cycles later only.
    ff_wreg_e = 1'b1; ff_uid_e = 3'd0; ff_rtaddr_e = 7'd5; ff_rt_e = 128'hA5; rd_addr_a = 7'd5;
    #1;
    check("t1_haz_c0", 128'(hazard_a), 128'd1);
    check("t1_we_c0", 128'(wb_we_e), 128'd0);
    tick(); idle(); #1;
    check("t1_haz_c1", 128'(hazard_a), 128'd1);
    check("t1_we_c1", 128'(wb_we_e), 128'd0);
    tick();
    check("t1_we_c2", 128'(wb_we_e), 128'd1);
    check("t1_addr_c2", 128'(wb_waddr_e), 128'd5);
    check("t1_data_c2", wb_wdata_e, 128'hA5);
    check("t1_haz_c2", 128'(hazard_a), 128'd1);
    tick();
    check("t1_we_c3", 128'(wb_we_e), 128'd0);
    check("t1_addr_c3", 128'(wb_waddr_e), 128'd0);
    check("t1_data_c3", wb_wdata_e, 128'd0);
    check("t1_haz_c3", 128'(hazard_a), 128'd0);

    // Odd uid2 (L=6) then odd uid1 (L=4) two cycles later: collision.
    ff_wreg_o = 1'b1; ff_uid_o = 3'd2; ff_rtaddr_o = 7'd3; ff_rt_o = 128'h33;
    #1;
    check("t2_pulse_c0", 128'(err_pulse), 128'd0);
    tick(); idle();
    tick();
    ff_wreg_o = 1'b1; ff_uid_o = 3'd1; ff_rtaddr_o = 7'd4; ff_rt_o = 128'h44;
    #1;
    check("t2_pulse_c2", 128'(err_pulse), 128'd1);
    check("t2_errst_c2", 128'(err_status), 128'd0);
    tick(); idle(); rd_addr_c = 7'd4; #1;
    check("t2_errst_c3", 128'(err_status), 128'd1);
    check("t2_pulse_c3", 128'(err_pulse), 128'd0);
    check("t2_haz_drop", 128'(hazard_c), 128'd0);
    tick(); tick();
    check("t2_we_c5", 128'(wb_we_o), 128'd0);
    tick();
    check("t2_we_c6", 128'(wb_we_o), 128'd1);
    check("t2_addr_c6", 128'(wb_waddr_o), 128'd3);
    check("t2_data_c6", wb_wdata_o, 128'h33);
    tick();
    check("t2_we_c7", 128'(wb_we_o), 128'd0);

    // Same-address retire on both pipes, then different addresses.
    ff_wreg_e = 1'b1; ff_uid_e = 3'd0; ff_rtaddr_e = 7'd9; ff_rt_e = 128'hE;
    tick(); idle();
    ff_wreg_o = 1'b1; ff_uid_o = 3'd5; ff_rtaddr_o = 7'd9; ff_rt_o = 128'hF;
    ff_wreg_e = 1'b1; ff_uid_e = 3'd0; ff_rtaddr_e = 7'd10; ff_rt_e = 128'hA;
    tick(); idle();
    ff_wreg_o = 1'b1; ff_uid_o = 3'd5; ff_rtaddr_o = 7'd11; ff_rt_o = 128'hB;
    #1;
    check("t3_clash_we_e", 128'(wb_we_e), 128'd0);
    check("t3_clash_data_e", wb_wdata_e, 128'd0);
    check("t3_clash_we_o", 128'(wb_we_o), 128'd1);
    check("t3_clash_addr_o", 128'(wb_waddr_o), 128'd9);
    check("t3_clash_data_o", wb_wdata_o, 128'hF);
    tick(); idle(); #1;
    check("t3_dual_we_e", 128'(wb_we_e), 128'd1);
    check("t3_dual_addr_e", 128'(wb_waddr_e), 128'd10);
    check("t3_dual_we_o", 128'(wb_we_o), 128'd1);
    check("t3_dual_addr_o", 128'(wb_waddr_o), 128'd11);

    // Asynchronous reset clears sticky error flags.
    rst = 1'b1;
    #1;
    check("rst2_errst", 128'(err_status), 128'd0);
    check("rst2_we_e", 128'(wb_we_e), 128'd0);
    tick();
    rst = 1'b0;

    // Bad uid on even pipe: discarded, bit1 sticky.
    ff_wreg_e = 1'b1; ff_uid_e = 3'd7; ff_rtaddr_e = 7'd12; ff_rt_e = 128'hC; rd_addr_b = 7'd12;
    #1;
    check("t4_pulse", 128'(err_pulse), 128'd1);
    check("t4_haz_bad", 128'(hazard_b), 128'd0);
    tick(); idle(); #1;
    check("t4_errst", 128'(err_status), 128'd2);
    check("t4_pulse_off", 128'(err_pulse), 128'd0);
    for (int k = 0; k < 8; k++) begin
      check("t4_no_write", 128'(wb_we_e), 128'd0);
      tick();
    end
    ff_uid_e = 3'd7; ff_wreg_e = 1'b0;
    #1;
    check("t4_nowreg_pulse", 128'(err_pulse), 128'd0);
    ff_uid_e = 3'd0; ff_wreg_o = 1'b1; ff_uid_o = 3'd6;
    #1;
    check("t4_odd_bad_pulse", 128'(err_pulse), 128'd1);
    tick(); idle(); #1;
    check("t4_errst_sticky", 128'(err_status), 128'd2);

    // Back-to-back branches with an in-flight odd uid2 entry.
    ff_wreg_o = 1'b1; ff_uid_o = 3'd2; ff_rtaddr_o = 7'd20; ff_rt_o = 128'h20;
    tick(); idle();
    tick(); tick(); tick();
    ff_branch_flag = 1'b1; ff_branch_target_addr = 32'h100;
    #1;
    check("t5_redir_c4", 128'(redirect_valid), 128'd0);
    tick();
    ff_branch_flag = 1'b1; ff_branch_target_addr = 32'h200;
    #1;
    check("t5_redir_c5", 128'(redirect_valid), 128'd1);
    check("t5_pc_c5", 128'(redirect_pc), 128'h100);
    tick(); idle(); #1;
    check("t5_redir_c6", 128'(redirect_valid), 128'd1);
    check("t5_pc_c6", 128'(redirect_pc), 128'h200);
    check("t5_we_o_c6", 128'(wb_we_o), 128'd1);
    check("t5_addr_o_c6", 128'(wb_waddr_o), 128'd20);
    tick();
    check("t5_redir_c7", 128'(redirect_valid), 128'd0);

    // Stream even uid2 entries, then reset mid-stream.
    for (int i = 0; i < 7; i++) begin
      ff_wreg_e = 1'b1; ff_uid_e = 3'd2; ff_rtaddr_e = 7'(30 + i); ff_rt_e = 128'(i);
      tick();
    end
    idle(); rd_addr_a = 7'd33;
    #1;
    check("t6_we_pre", 128'(wb_we_e), 128'd1);
    check("t6_addr_pre", 128'(wb_waddr_e), 128'd31);
    check("t6_haz_pre", 128'(hazard_a), 128'd1);
    rst = 1'b1;
    #1;
    check("t6_we_rst", 128'(wb_we_e), 128'd0);
    check("t6_addr_rst", 128'(wb_waddr_e), 128'd0);
    check("t6_haz_rst", 128'(hazard_a), 128'd0);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t6_no_retire", 128'(wb_we_e), 128'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
